// File: rtl/cursor_ctrl.sv
// cursor_ctrl: positions a cursor inside a W x H drawing space from mouse packets and arrow keys.
// Packets pass through IDLE/CALC/COMMIT; key steps are applied only on otherwise idle cycles.
module cursor_ctrl #(
    parameter int W             = 640,
    parameter int H             = 480,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 2_500_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        delta_valid,
    input  logic [8:0]  delta_x,
    input  logic [8:0]  delta_y,
    input  logic        btn_left,
    output logic        delta_ready,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_left,
    input  logic        key_right,
    output logic [10:0] cursorX,
    output logic [10:0] cursorY,
    output logic        draw_en,
    output logic        pos_update
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CALC   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    localparam logic [10:0] POS_MIN = 11'd1;
    localparam logic [10:0] X_MAX   = 11'(W - 2);
    localparam logic [10:0] Y_MAX   = 11'(H - 2);
    localparam logic [10:0] X_RST   = 11'(W / 2);
    localparam logic [10:0] Y_RST   = 11'(H / 2);

    localparam logic signed [11:0] SX_MAX = 12'(W - 2);
    localparam logic signed [11:0] SY_MAX = 12'(H - 2);
    localparam logic signed [11:0] S_MIN  = 12'sd1;

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [1:0]         state_reg;
    logic [1:0]         state_next;
    logic [10:0]        cursor_x_reg;
    logic [10:0]        cursor_y_reg;
    logic               draw_en_reg;
    logic               pos_update_reg;
    logic [8:0]         dx_reg;
    logic [8:0]         dy_reg;
    logic               btn_reg;
    logic signed [11:0] nx_reg;
    logic signed [11:0] ny_reg;
    logic [3:0]         pend_reg;
    logic [3:0]         pend_next;

    logic [3:0]  keys;
    logic [3:0]  key_req;
    logic        key_apply;
    logic [10:0] step_x;
    logic [10:0] step_y;
    logic [10:0] clamp_x;
    logic [10:0] clamp_y;

    // Bit order: 0 = up, 1 = down, 2 = left, 3 = right.
    assign keys = {key_right, key_left, key_down, key_up};

    // Each key raises a request on its press edge, once more after REPEAT_DELAY held
    // cycles, and then every REPEAT_PERIOD cycles until it is released.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            logic [CNT_W-1:0] hold_cnt_reg;
            logic             repeat_reg;
            logic             prev_reg;
            logic             hold_done;

            assign hold_done   = (hold_cnt_reg == (repeat_reg ? PERIOD_LAST : DELAY_LAST));
            assign key_req[gi] = keys[gi] & (~prev_reg | hold_done);

            always_ff @(posedge clk) begin
                if (reset) begin
                    hold_cnt_reg <= '0;
                    repeat_reg   <= 1'b0;
                    prev_reg     <= 1'b0;
                end else begin
                    prev_reg <= keys[gi];
                    if (!keys[gi]) begin
                        hold_cnt_reg <= '0;
                        repeat_reg   <= 1'b0;
                    end else if (!prev_reg) begin
                        hold_cnt_reg <= '0;
                    end else if (hold_done) begin
                        hold_cnt_reg <= '0;
                        repeat_reg   <= 1'b1;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
            end
        end
    endgenerate

    // A packet always takes priority over pending key steps in IDLE.
    assign key_apply = (state_reg == IDLE) & ~delta_valid & (|pend_reg);
    assign pend_next = key_apply ? key_req : (pend_reg | key_req);

    // Opposite requests on one axis cancel; steps stop at the border limits.
    always_comb begin
        step_x = cursor_x_reg;
        step_y = cursor_y_reg;
        if (pend_reg[3] && !pend_reg[2] && (cursor_x_reg < X_MAX)) begin
            step_x = cursor_x_reg + 11'd1;
        end else if (pend_reg[2] && !pend_reg[3] && (cursor_x_reg > POS_MIN)) begin
            step_x = cursor_x_reg - 11'd1;
        end
        if (pend_reg[1] && !pend_reg[0] && (cursor_y_reg < Y_MAX)) begin
            step_y = cursor_y_reg + 11'd1;
        end else if (pend_reg[0] && !pend_reg[1] && (cursor_y_reg > POS_MIN)) begin
            step_y = cursor_y_reg - 11'd1;
        end
    end

    always_comb begin
        if (nx_reg < S_MIN) begin
            clamp_x = POS_MIN;
        end else if (nx_reg > SX_MAX) begin
            clamp_x = X_MAX;
        end else begin
            clamp_x = nx_reg[10:0];
        end
        if (ny_reg < S_MIN) begin
            clamp_y = POS_MIN;
        end else if (ny_reg > SY_MAX) begin
            clamp_y = Y_MAX;
        end else begin
            clamp_y = ny_reg[10:0];
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (delta_valid) state_next = CALC;
            CALC:    state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cursor_x_reg   <= X_RST;
            cursor_y_reg   <= Y_RST;
            draw_en_reg    <= 1'b0;
            pos_update_reg <= 1'b0;
            dx_reg         <= '0;
            dy_reg         <= '0;
            btn_reg        <= 1'b0;
            nx_reg         <= '0;
            ny_reg         <= '0;
            pend_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            pend_reg       <= pend_next;
            pos_update_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (delta_valid) begin
                        dx_reg  <= delta_x;
                        dy_reg  <= delta_y;
                        btn_reg <= btn_left;
                    end else if (key_apply) begin
                        cursor_x_reg   <= step_x;
                        cursor_y_reg   <= step_y;
                        pos_update_reg <= (step_x != cursor_x_reg) | (step_y != cursor_y_reg);
                    end
                end
                CALC: begin
                    // Screen Y grows downward while mouse Y is positive-up.
                    nx_reg <= $signed({1'b0, cursor_x_reg}) + $signed({{3{dx_reg[8]}}, dx_reg});
                    ny_reg <= $signed({1'b0, cursor_y_reg}) - $signed({{3{dy_reg[8]}}, dy_reg});
                end
                COMMIT: begin
                    cursor_x_reg   <= clamp_x;
                    cursor_y_reg   <= clamp_y;
                    draw_en_reg    <= btn_reg;
                    pos_update_reg <= (clamp_x != cursor_x_reg) | (clamp_y != cursor_y_reg)
                                      | (btn_reg != draw_en_reg);
                end
                default: ;
            endcase
        end
    end

    assign delta_ready = (state_reg == IDLE);
    assign cursorX     = cursor_x_reg;
    assign cursorY     = cursor_y_reg;
    assign draw_en     = draw_en_reg;
    assign pos_update  = pos_update_reg;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Self-checking bench for cursor_ctrl: directed boundary cases plus random packets and key taps
// compared against an arithmetic position model.
module tb_cursor_ctrl;
    localparam int W = 640;
    localparam int H = 480;
    localparam int D = 8;
    localparam int P = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        delta_valid = 1'b0;
    logic [8:0]  delta_x = '0;
    logic [8:0]  delta_y = '0;
    logic        btn_left = 1'b0;
    logic        delta_ready;
    logic        key_up = 1'b0;
    logic        key_down = 1'b0;
    logic        key_left = 1'b0;
    logic        key_right = 1'b0;
    logic [10:0] cursorX;
    logic [10:0] cursorY;
    logic        draw_en;
    logic        pos_update;

    int n_checks = 0;
    int n_fail = 0;
    int mx;
    int my;
    int mdraw;

    cursor_ctrl #(
        .W(W), .H(H), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)
    ) dut (
        .clk(clk), .reset(reset),
        .delta_valid(delta_valid), .delta_x(delta_x), .delta_y(delta_y),
        .btn_left(btn_left), .delta_ready(delta_ready),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .cursorX(cursorX), .cursorY(cursorY), .draw_en(draw_en), .pos_update(pos_update)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic check_pos(input string tag);
        chk({tag, "_x"}, int'(cursorX), mx);
        chk({tag, "_y"}, int'(cursorY), my);
        chk({tag, "_draw"}, int'(draw_en), mdraw);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        delta_valid = 1'b0;
        {key_right, key_left, key_down, key_up} = 4'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        mx = W / 2;
        my = H / 2;
        mdraw = 0;
        check_pos("rst");
        chk("rst_upd", int'(pos_update), 0);
        chk("rst_ready", int'(delta_ready), 1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_packet(input int dx, input int dy, input int btn);
        int ex;
        int ey;
        int changed;
        @(negedge clk);
        chk("pkt_ready", int'(delta_ready), 1);
        delta_valid = 1'b1;
        delta_x = dx[8:0];
        delta_y = dy[8:0];
        btn_left = btn[0];
        @(posedge clk);
        #1;
        chk("pkt_busy", int'(delta_ready), 0);
        @(negedge clk);
        delta_valid = 1'b0;
        delta_x = 9'($urandom);
        delta_y = 9'($urandom);
        btn_left = 1'($urandom);
        @(posedge clk);
        #1;
        chk("pkt_early_upd", int'(pos_update), 0);
        chk("pkt_early_x", int'(cursorX), mx);
        @(posedge clk);
        #1;
        ex = clampi(mx + dx, 1, W - 2);
        ey = clampi(my - dy, 1, H - 2);
        changed = (ex != mx || ey != my || btn != mdraw) ? 1 : 0;
        mx = ex;
        my = ey;
        mdraw = btn;
        check_pos("pkt");
        chk("pkt_upd", int'(pos_update), changed);
        @(posedge clk);
        #1;
        chk("pkt_upd_len", int'(pos_update), 0);
    endtask

    // m = {right, left, down, up}; keys are held for exactly one sampled edge.
    task automatic key_tap(input logic [3:0] m);
        int ex;
        int ey;
        @(negedge clk);
        {key_right, key_left, key_down, key_up} = m;
        @(posedge clk);
        @(negedge clk);
        {key_right, key_left, key_down, key_up} = 4'b0;
        @(posedge clk);
        #1;
        ex = clampi(mx + int'(m[3]) - int'(m[2]), 1, W - 2);
        ey = clampi(my + int'(m[1]) - int'(m[0]), 1, H - 2);
        chk("key_upd", int'(pos_update), (ex != mx || ey != my) ? 1 : 0);
        mx = ex;
        my = ey;
        check_pos("key");
        @(posedge clk);
        #1;
        chk("key_upd_len", int'(pos_update), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        int n_hold;
        int exp_steps;
        int x0;

        do_reset();
        send_packet(10, 5, 1);

        do_reset();
        repeat (3) send_packet(-255, 0, 0);

        do_reset();
        send_packet(255, 0, 0);
        send_packet(62, 0, 0);
        send_packet(100, 0, 0);
        repeat (2) send_packet(0, -255, 0);

        // Auto-repeat while holding key_right.
        do_reset();
        pulses = 0;
        n_hold = D + 3 * P;
        exp_steps = 1 + ((n_hold > D) ? ((n_hold - D - 1) / P + 1) : 0);
        x0 = mx;
        for (int i = 0; i < n_hold + 6; i++) begin
            @(negedge clk);
            key_right = (i < n_hold);
            @(posedge clk);
            #1;
            if (pos_update) pulses++;
        end
        chk("hold_pulses", pulses, exp_steps);
        mx = clampi(x0 + exp_steps, 1, W - 2);
        check_pos("hold");

        // key_up in the same cycle as a packet that only toggles the button.
        @(negedge clk);
        delta_valid = 1'b1;
        delta_x = '0;
        delta_y = '0;
        btn_left = ~draw_en;
        key_up = 1'b1;
        @(posedge clk);
        @(negedge clk);
        delta_valid = 1'b0;
        key_up = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        mdraw = 1 - mdraw;
        check_pos("race_pkt");
        chk("race_pkt_upd", int'(pos_update), 1);
        @(posedge clk);
        #1;
        my = clampi(my - 1, 1, H - 2);
        check_pos("race_key");
        chk("race_key_upd", int'(pos_update), 1);

        // Reset while the packet sits in CALC.
        do_reset();
        @(negedge clk);
        delta_valid = 1'b1;
        delta_x = 9'd50;
        delta_y = 9'd0;
        btn_left = 1'b1;
        @(posedge clk);
        @(negedge clk);
        delta_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_pos("abort");
        chk("abort_ready", int'(delta_ready), 1);
        chk("abort_upd", int'(pos_update), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort_after_upd", int'(pos_update), 0);
            chk("abort_after_x", int'(cursorX), mx);
        end

        // Random mix of packets and key taps.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 4) == 0)
                    send_packet(0, 0, ($urandom_range(0, 3) == 0) ? 1 - mdraw : mdraw);
                else
                    send_packet(int'($urandom_range(0, 510)) - 255,
                                int'($urandom_range(0, 510)) - 255,
                                int'($urandom_range(0, 1)));
            end else begin
                key_tap(4'($urandom_range(1, 15)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
